// File: rtl/drive_sequencer_if.sv
// Command/status bundle between the steering logic, the drive sequencer and the wheel pulse generators.
interface drive_sequencer_if;
   logic       enable;
   logic       cmd_fwd;
   logic       cmd_left;
   logic       cmd_right;
   logic       too_close;
   logic       fwd_l;
   logic       bwd_l;
   logic       fwd_r;
   logic       bwd_r;
   logic       busy;
   logic [2:0] state;

   modport master (
      output enable, cmd_fwd, cmd_left, cmd_right, too_close,
      input  fwd_l, bwd_l, fwd_r, bwd_r, busy, state
   );

   modport slave (
      input  enable, cmd_fwd, cmd_left, cmd_right, too_close,
      output fwd_l, bwd_l, fwd_r, bwd_r, busy, state
   );
endinterface

// File: rtl/drive_sequencer.sv
// Drive-motor sequencer: arbitrates steering against the obstacle flag, runs the
// reverse/pivot avoidance manoeuvre and inserts dead-time after every nonzero wheel command.
//
//   state   | meaning
//   IDLE    | motors off, waiting for enable with a command or obstacle
//   DRIVE   | steering vector applied, re-arbitrated every cycle
//   DEAD    | all-zero dead-time; pend selects where it exits
//   BACKOFF | reverse both wheels for the back-off window
//   PIVOT   | spin right after back-off
module drive_sequencer #(
   parameter int DEADTIME_CYCLES = 50000,
   parameter int BACKOFF_CYCLES  = 600000,
   parameter int PIVOT_CYCLES    = 400000,
   parameter int CNT_W           = 32
) (
   input logic              clk,
   input logic              rst_n,
   drive_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRIVE   = 3'd1,
      DEAD    = 3'd2,
      BACKOFF = 3'd3,
      PIVOT   = 3'd4
   } stateT;

   typedef enum logic [1:0] {
      PEND_NONE  = 2'd0,
      PEND_AVOID = 2'd1,
      PEND_PIVOT = 2'd2
   } pendT;

   // Vector order {fwd_l, bwd_l, fwd_r, bwd_r}; left wheel is mirror-mounted.
   localparam logic [3:0] VEC_FWD   = 4'b0110;
   localparam logic [3:0] VEC_LEFT  = 4'b1010;
   localparam logic [3:0] VEC_RIGHT = 4'b0101;
   localparam logic [3:0] VEC_REV   = 4'b1001;
   localparam logic [3:0] VEC_PIVOT = 4'b0101;
   localparam logic [3:0] VEC_OFF   = 4'b0000;

   localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEADTIME_CYCLES - 1);
   localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0] PIVOT_LAST   = CNT_W'(PIVOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   stateT            curState, nextState;
   pendT             pend, nextPend;
   logic [3:0]       vec, nextVec;
   logic [CNT_W-1:0] cnt, nextCnt;
   logic [3:0]       target;
   logic             anyCmd;

   always_comb begin
      target = VEC_OFF;
      if (bus.cmd_left)       target = VEC_LEFT;
      else if (bus.cmd_fwd)   target = VEC_FWD;
      else if (bus.cmd_right) target = VEC_RIGHT;
   end

   assign anyCmd = bus.cmd_fwd | bus.cmd_left | bus.cmd_right;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState <= IDLE;
         pend     <= PEND_NONE;
         vec      <= VEC_OFF;
         cnt      <= '0;
      end else begin
         curState <= nextState;
         pend     <= nextPend;
         vec      <= nextVec;
         cnt      <= nextCnt;
      end
   end

   always_comb begin
      nextState = curState;
      nextPend  = pend;
      nextVec   = vec;
      nextCnt   = cnt;
      if (!bus.enable) begin
         // Counter parks at zero so the full dead-time runs once enable returns.
         nextState = DEAD;
         nextPend  = PEND_NONE;
         nextVec   = VEC_OFF;
         nextCnt   = '0;
      end else begin
         case (curState)
            IDLE: begin
               if (bus.too_close) begin
                  nextState = BACKOFF;
                  nextVec   = VEC_REV;
                  nextCnt   = '0;
               end else if (anyCmd) begin
                  nextState = DRIVE;
                  nextVec   = target;
               end
            end
            DRIVE: begin
               if (bus.too_close || target != vec) begin
                  nextState = DEAD;
                  nextPend  = bus.too_close ? PEND_AVOID : PEND_NONE;
                  nextVec   = VEC_OFF;
                  nextCnt   = '0;
               end
            end
            DEAD: begin
               nextCnt = cnt + CNT_ONE;
               if (bus.too_close) nextPend = PEND_AVOID;
               if (cnt == DEAD_LAST) begin
                  nextCnt  = '0;
                  nextPend = PEND_NONE;
                  if (bus.too_close || pend == PEND_AVOID) begin
                     nextState = BACKOFF;
                     nextVec   = VEC_REV;
                  end else if (pend == PEND_PIVOT) begin
                     nextState = PIVOT;
                     nextVec   = VEC_PIVOT;
                  end else if (anyCmd) begin
                     nextState = DRIVE;
                     nextVec   = target;
                  end else begin
                     nextState = IDLE;
                  end
               end
            end
            BACKOFF: begin
               nextCnt = cnt + CNT_ONE;
               if (cnt == BACKOFF_LAST) begin
                  nextCnt = '0;
                  if (!bus.too_close) begin
                     nextState = DEAD;
                     nextPend  = PEND_PIVOT;
                     nextVec   = VEC_OFF;
                  end
               end
            end
            PIVOT: begin
               nextCnt = cnt + CNT_ONE;
               if (bus.too_close || cnt == PIVOT_LAST) begin
                  nextState = DEAD;
                  nextPend  = bus.too_close ? PEND_AVOID : PEND_NONE;
                  nextVec   = VEC_OFF;
                  nextCnt   = '0;
               end
            end
            default: begin
               nextState = IDLE;
               nextPend  = PEND_NONE;
               nextVec   = VEC_OFF;
               nextCnt   = '0;
            end
         endcase
      end
   end

   assign bus.fwd_l = vec[3];
   assign bus.bwd_l = vec[2];
   assign bus.fwd_r = vec[1];
   assign bus.bwd_r = vec[0];
   assign bus.state = curState;
   assign bus.busy  = (curState == BACKOFF) || (curState == PIVOT) || (pend != PEND_NONE);

endmodule

// File: tb/tb_drive_sequencer.sv
// Self-checking bench for drive_sequencer: vector table, directed manoeuvre sequences,
// then randomized stimulus against a remaining-cycles behavioural model.
module tb_drive_sequencer;
   localparam int DT = 4;
   localparam int BO = 10;
   localparam int PV = 6;

   localparam logic [3:0] FWD = 4'b0110, LFT = 4'b1010, RGT = 4'b0101;
   localparam logic [3:0] REV = 4'b1001, PIV = 4'b0101, OFF = 4'b0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   drive_sequencer_if bus ();

   drive_sequencer #(
      .DEADTIME_CYCLES(DT),
      .BACKOFF_CYCLES (BO),
      .PIVOT_CYCLES   (PV),
      .CNT_W          (32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en, f, l, r, tc;
      logic [3:0] v;
      logic [2:0] s;
      logic       b;
   } vecT;

   vecT tbl[$];

   // behavioural model: mode numbers are the visible state codes, mLeft counts cycles still to run
   int         mMode, mLeft, mPend;
   logic [3:0] mVec;
   logic       mBusy;

   task automatic check(input string name, input logic [3:0] v, input logic [2:0] s, input logic b);
      logic [3:0] got;
      got = {bus.fwd_l, bus.bwd_l, bus.fwd_r, bus.bwd_r};
      checks++;
      if (got !== v || bus.state !== s || bus.busy !== b) begin
         errors++;
         $display("FAIL %s @%0t: got vec=%b state=%0d busy=%b, want vec=%b state=%0d busy=%b",
                  name, $time, got, bus.state, bus.busy, v, s, b);
      end
   endtask

   task automatic drive(input logic en, input logic f, input logic l, input logic r, input logic tc);
      bus.enable    = en;
      bus.cmd_fwd   = f;
      bus.cmd_left  = l;
      bus.cmd_right = r;
      bus.too_close = tc;
   endtask

   task automatic runChk(input string name, input logic en, input logic f, input logic l, input logic r,
                         input logic tc, input logic [3:0] v, input logic [2:0] s, input logic b, input int n);
      drive(en, f, l, r, tc);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check(name, v, s, b);
      end
   endtask

   task automatic add(input logic en, input logic f, input logic l, input logic r, input logic tc,
                      input logic [3:0] v, input logic [2:0] s, input logic b, input int n);
      vecT e;
      e.en = en; e.f = f; e.l = l; e.r = r; e.tc = tc; e.v = v; e.s = s; e.b = b;
      for (int i = 0; i < n; i++) tbl.push_back(e);
   endtask

   task automatic enterDead(input int p);
      mMode = 2; mLeft = DT; mPend = p; mVec = OFF;
   endtask

   task automatic modelStep(input logic en, input logic f, input logic l, input logic r, input logic tc);
      logic [3:0] t;
      t = l ? LFT : f ? FWD : r ? RGT : OFF;
      if (!en) enterDead(0);
      else case (mMode)
         0: if (tc) begin mMode = 3; mLeft = BO; mVec = REV; end
            else if (t != OFF) begin mMode = 1; mVec = t; end
         1: if (tc) enterDead(1);
            else if (t != mVec) enterDead(0);
         2: begin
            if (tc) mPend = 1;
            mLeft--;
            if (mLeft == 0) begin
               if (mPend == 1)      begin mMode = 3; mLeft = BO; mVec = REV; end
               else if (mPend == 2) begin mMode = 4; mLeft = PV; mVec = PIV; end
               else if (t != OFF)   begin mMode = 1; mVec = t; end
               else                 begin mMode = 0; mVec = OFF; end
               mPend = 0;
            end
         end
         3: begin
            mLeft--;
            if (mLeft == 0) begin
               if (tc) mLeft = BO;
               else enterDead(2);
            end
         end
         4: if (tc) enterDead(1);
            else begin
               mLeft--;
               if (mLeft == 0) enterDead(0);
            end
         default: ;
      endcase
      mBusy = (mMode == 3) || (mMode == 4) || (mPend != 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset", OFF, 3'd0, 1'b0);
      rst_n = 1'b1;

      // single-cycle commands, dead-time on removal, vector change through DEAD
      add(1, 1, 0, 0, 0, FWD, 1, 0, 1);
      add(1, 0, 0, 0, 0, OFF, 2, 0, DT);
      add(1, 0, 0, 0, 0, OFF, 0, 0, 1);
      add(1, 1, 0, 0, 0, FWD, 1, 0, 2);
      add(1, 1, 1, 0, 0, OFF, 2, 0, DT);
      add(1, 1, 1, 0, 0, LFT, 1, 0, 2);
      add(1, 0, 1, 0, 0, LFT, 1, 0, 1);
      add(1, 0, 0, 0, 0, OFF, 2, 0, DT);
      add(1, 0, 0, 0, 0, OFF, 0, 0, 1);
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].f, tbl[i].l, tbl[i].r, tbl[i].tc);
         @(posedge clk);
         #1;
         check($sformatf("table[%0d]", i), tbl[i].v, tbl[i].s, tbl[i].b);
      end

      // full manoeuvre after a one-cycle obstacle pulse in DRIVE
      runChk("m_drive", 1, 1, 0, 0, 0, FWD, 1, 0, 1);
      runChk("m_pulse", 1, 0, 0, 0, 1, OFF, 2, 1, 1);
      runChk("m_dead1", 1, 0, 0, 0, 0, OFF, 2, 1, DT - 1);
      runChk("m_rev",   1, 0, 0, 0, 0, REV, 3, 1, BO);
      runChk("m_dead2", 1, 0, 0, 0, 0, OFF, 2, 1, DT);
      runChk("m_pivot", 1, 0, 0, 0, 0, PIV, 4, 1, PV);
      runChk("m_dead3", 1, 0, 0, 0, 0, OFF, 2, 0, DT);
      runChk("m_idle",  1, 0, 0, 0, 0, OFF, 0, 0, 1);

      // obstacle on the final back-off cycle restarts the window; obstacle in pivot re-avoids
      runChk("r_enter",   1, 0, 0, 0, 1, REV, 3, 1, 1);
      runChk("r_win1",    1, 0, 0, 0, 0, REV, 3, 1, BO - 1);
      runChk("r_last_tc", 1, 0, 0, 0, 1, REV, 3, 1, 1);
      runChk("r_win2",    1, 0, 0, 0, 0, REV, 3, 1, BO - 1);
      runChk("r_exit",    1, 0, 0, 0, 0, OFF, 2, 1, 1);
      runChk("r_dead",    1, 0, 0, 0, 0, OFF, 2, 1, DT - 1);
      runChk("r_piv",     1, 0, 0, 0, 0, PIV, 4, 1, 3);
      runChk("r_piv_tc",  1, 0, 0, 0, 1, OFF, 2, 1, 1);
      runChk("r_dead2",   1, 0, 0, 0, 0, OFF, 2, 1, DT - 1);
      runChk("r_rev2",    1, 0, 0, 0, 0, REV, 3, 1, 4);

      // enable drop mid back-off: dead-time held, then a full dead-time after return
      runChk("e_off",   0, 0, 0, 1, 0, OFF, 2, 0, 7);
      runChk("e_on",    1, 0, 0, 1, 0, OFF, 2, 0, DT - 1);
      runChk("e_drive", 1, 0, 0, 1, 0, RGT, 1, 0, 1);

      // asynchronous reset in the middle of dead-time
      runChk("x_drop", 1, 0, 0, 0, 0, OFF, 2, 0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("x_async_reset", OFF, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      runChk("x_right", 1, 0, 0, 1, 0, RGT, 1, 0, 1);

      // randomized run against the model
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mMode = 0; mLeft = 0; mPend = 0; mVec = OFF; mBusy = 1'b0;
      begin
         logic en, f, l, r, tc;
         int   hold;
         en = 1'b1; f = 1'b0; l = 1'b0; r = 1'b0; tc = 1'b0; hold = 0;
         for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
               en   = ($urandom_range(15) != 0);
               f    = ($urandom_range(2) == 0);
               l    = ($urandom_range(3) == 0);
               r    = ($urandom_range(2) == 0);
               tc   = ($urandom_range(9) == 0);
               hold = (tc || !en) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 12));
            end
            hold--;
            drive(en, f, l, r, tc);
            modelStep(en, f, l, r, tc);
            @(posedge clk);
            #1;
            check("random", mVec, mMode[2:0], mBusy);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Drive-motor sequencer and command arbiter between the robot's sensor/steering logic and the two per-wheel motor pulse generators. It arbitrates the obstacle flag against the steering commands and runs a timed obstacle-avoidance manoeuvre: reverse, then pivot. It inserts a dead-time of all-zero wheel commands whenever a nonzero wheel command is removed, which protects the drive hardware. Outputs are the forward/backward request bits that feed the existing per-wheel pulse generators directly.

## Interface

- DEADTIME_CYCLES, 50000: cycles of all-zero wheel command inserted on every exit from a nonzero command (≥1)
- BACKOFF_CYCLES, 600000: cycles of reverse drive per back-off window (≥1)
- PIVOT_CYCLES, 400000: cycles of right spin after back-off (≥1)
- CNT_W, 32: duration counter width; every duration parameter must fit in it

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  0 = force motors off via dead-time
- cmd_fwd  in  1  steering request: drive forward
- cmd_left  in  1  steering request: spin left
- cmd_right  in  1  steering request: spin right
- too_close  in  1  obstacle flag, starts/extends avoidance
- fwd_l, bwd_l  out  1 each  left wheel requests (registered)
- fwd_r, bwd_r  out  1 each  right wheel requests (registered)
- busy  out  1  avoidance in progress: state BACKOFF/PIVOT, or pending AVOID/PIVOT
- state  out  3  IDLE=0, DRIVE=1, DEAD=2, BACKOFF=3, PIVOT=4

## Operation

- Wheel vectors {fwd_l,bwd_l,fwd_r,bwd_r}: FWD=0110, LEFT=1010, RIGHT=0101, REV=1001, PIVOT=0101, OFF=0000. The left wheel is mirror-mounted.
- Steering priority: cmd_left > cmd_fwd > cmd_right. too_close outranks all of them.
- pend register: NONE, AVOID or PIVOT. It selects where DEAD exits.
- IDLE: outputs OFF.
  - enable and too_close → BACKOFF.
  - Otherwise enable and any cmd → DRIVE with the priority vector.
  - Otherwise stay.
- DRIVE: re-evaluate the target every cycle.
  - too_close → DEAD, pend=AVOID.
  - Target equals current vector → stay.
  - Any other target, including no command → DEAD, pend=NONE.
- DEAD: outputs OFF for exactly DEADTIME_CYCLES cycles.
  - too_close seen during DEAD sets pend=AVOID.
  - Steering inputs are sampled only in the final DEAD cycle.
  - Exit: pend AVOID → BACKOFF. pend PIVOT → PIVOT. NONE → DRIVE if any cmd, else IDLE. pend clears on exit.
- BACKOFF: outputs REV for BACKOFF_CYCLES cycles.
  - too_close mid-window is ignored.
  - If too_close is 1 in the final cycle, the counter restarts and a full new window runs.
  - Otherwise → DEAD, pend=PIVOT.
- PIVOT: outputs PIVOT for PIVOT_CYCLES cycles, then → DEAD, pend=NONE.
  - too_close during PIVOT → DEAD, pend=AVOID.
- enable=0, any state: next state DEAD, pend=NONE, counter held at 0 while enable=0. The full dead-time then runs after enable returns to 1.
- Invariant: every transition out of a nonzero vector passes through DEAD, so no two different nonzero vectors are ever adjacent on the outputs.
- Counter: CNT_W-bit up-counter, cleared on every state entry. It never wraps because terminal compares use `==` against the parameter minus 1.

## Timing

- Reset (async assert): state=IDLE, outputs 0000, busy=0, pend=NONE, counter=0. Deassertion is assumed synchronised upstream.
- Inputs are sampled at posedge. Outputs are registered and reflect the state entered at that same edge.
- Input-to-output latency is 1 cycle.
- IDLE→DRIVE: cmd high before edge k gives the vector valid after edge k.
- A vector change from DRIVE gives OFF for DEADTIME_CYCLES cycles, then the new vector.
- A state of duration N holds its outputs for exactly N clock cycles.
- Simultaneous cmd_left and cmd_fwd resolve to LEFT. too_close together with any cmd resolves to avoidance.
- rst_n asserted mid-manoeuvre aborts immediately to reset values, with no dead-time.

## Test plan

Parameters for all scenarios: DEADTIME_CYCLES=4, BACKOFF_CYCLES=10, PIVOT_CYCLES=6.

- Reset, then cmd_fwd=1 for 1 cycle → outputs 0110 one cycle later, state=1, busy=0. Then cmd drops → 4 cycles 0000 (state=2), then state=0.
- cmd_fwd held, then cmd_left added → 0110, then exactly 4 cycles 0000, then 1010. There is never a direct 0110→1010 step.
- too_close pulsed 1 cycle in DRIVE → 4×0000, 10×1001, 4×0000, 6×0101, 4×0000, then IDLE. busy=1 from the pulse until PIVOT exits.
- too_close held through the last BACKOFF cycle → a second full 10-cycle REV window. too_close pulsed in PIVOT cycle 3 → 4×0000, then a new 10×1001.
- enable=0 for 7 cycles during BACKOFF → outputs 0000 from the next cycle, state=2 held. After enable=1: 4 more 0000 cycles, then IDLE/DRIVE per cmds, and busy=0.
- rst_n low mid-DEAD → outputs 0000 and state=0 immediately (asynchronous). After release, cmd_right gives 0101 one cycle later.
